// File: rtl/move_history_stack.sv
`default_nettype none
// ============================================================================
// Module   : move_history_stack
// Purpose  : LIFO of committed chess moves feeding the board updater (forward
//            apply on commit, undo replay on pop). MOVE_HISTORY_REDO_EN adds redo.
// Revision : 1.0 - initial release
// ============================================================================
module move_history_stack #(
  parameter int DEPTH = 256,
  parameter int PTR_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_valid,
  output logic             push_ready,
  input  logic             in_color,
  input  logic [63:0]      in_initial,
  input  logic [63:0]      in_moved,
  input  logic [5:0]       in_moving,
  input  logic [5:0]       in_captured,
  input  logic [1:0]       in_castling,
  input  logic [4:0]       in_enpassant,
  input  logic             undo_req,
  output logic             undo_ack,
`ifdef MOVE_HISTORY_REDO_EN
  input  logic             redo_req,
  output logic             redo_ack,
`endif
  output logic             out_valid,
  output logic             out_undo,
  output logic             out_color,
  output logic [63:0]      out_initial,
  output logic [63:0]      out_moved,
  output logic [5:0]       out_moving,
  output logic [5:0]       out_captured,
  output logic [1:0]       out_castling,
  output logic [4:0]       out_enpassant,
  output logic [PTR_W:0]   count,
  output logic             empty,
  output logic             full,
  output logic             err
);

  localparam int             REC_W    = 35;
  localparam logic [PTR_W:0] CNT_ONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W:0] CNT_FULL = (PTR_W+1)'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PUSH_OUT = 2'd1,
    ST_POP_RD   = 2'd2,
    ST_POP_OUT  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             err_q, err_d;
  logic             dir_q, dir_d;
  logic             load_push;
  logic             push_ok;
  logic             ram_we, ram_re;
  logic [PTR_W-1:0] ram_addr;
  logic [PTR_W:0]   count_dec;
  logic [REC_W-1:0] ram_wdata;
  logic [31:0]      rdata_q;
  logic [REC_W-1:0] mem_q [DEPTH];

  logic             out_undo_q, out_color_q;
  logic [63:0]      out_initial_q, out_moved_q;
  logic [5:0]       out_moving_q, out_captured_q;
  logic [1:0]       out_castling_q;
  logic [4:0]       out_enpassant_q;

`ifdef MOVE_HISTORY_REDO_EN
  logic [PTR_W:0]   redo_top_q, redo_top_d;
`endif

  function automatic logic onehot64(input logic [63:0] v);
    return (v != '0) && ((v & (v - 64'd1)) == '0);
  endfunction

  function automatic logic onehot6(input logic [5:0] v);
    return (v != '0) && ((v & (v - 6'd1)) == '0);
  endfunction

  function automatic logic [5:0] idx64(input logic [63:0] v);
    logic [5:0] idx;
    idx = '0;
    for (int i = 0; i < 64; i++) begin
      if (v[i]) idx = 6'(i);
    end
    return idx;
  endfunction

  assign empty     = (count_q == '0);
  assign full      = (count_q == CNT_FULL);
  assign count     = count_q;
  assign err       = err_q;
  assign count_dec = count_q - CNT_ONE;
  assign push_ok   = onehot64(in_initial) && onehot64(in_moved) && onehot6(in_moving);
  // Record layout, LSB first: origin idx, dest idx, moving, captured, castling, ep, colour, spare.
  assign ram_wdata = {3'b000, in_color, in_enpassant, in_castling, in_captured,
                      in_moving, idx64(in_moved), idx64(in_initial)};

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    err_d      = err_q;
    dir_d      = dir_q;
    push_ready = 1'b0;
    undo_ack   = 1'b0;
    load_push  = 1'b0;
    ram_we     = 1'b0;
    ram_re     = 1'b0;
    ram_addr   = count_q[PTR_W-1:0];
`ifdef MOVE_HISTORY_REDO_EN
    redo_ack   = 1'b0;
    redo_top_d = redo_top_q;
`endif
    case (state_q)
      ST_IDLE: begin
        push_ready = !full;
        if (push_valid && !full) begin
          if (push_ok) begin
            ram_we    = 1'b1;
            load_push = 1'b1;
            count_d   = count_q + CNT_ONE;
            state_d   = ST_PUSH_OUT;
`ifdef MOVE_HISTORY_REDO_EN
            redo_top_d = count_q + CNT_ONE;
`endif
          end else begin
            err_d = 1'b1;
          end
        end else if (undo_req) begin
          undo_ack = 1'b1;
          if (!empty) begin
            ram_re   = 1'b1;
            ram_addr = count_dec[PTR_W-1:0];
            count_d  = count_dec;
            dir_d    = 1'b1;
            state_d  = ST_POP_RD;
          end else begin
            err_d = 1'b1;
          end
        end
`ifdef MOVE_HISTORY_REDO_EN
        else if (redo_req) begin
          redo_ack = 1'b1;
          // A pop leaves its entry in RAM, so the slot at count is still the undone move.
          if (count_q < redo_top_q) begin
            ram_re  = 1'b1;
            count_d = count_q + CNT_ONE;
            dir_d   = 1'b0;
            state_d = ST_POP_RD;
          end else begin
            err_d = 1'b1;
          end
        end
`endif
      end
      ST_PUSH_OUT: state_d = ST_IDLE;
      ST_POP_RD:   state_d = ST_POP_OUT;
      ST_POP_OUT:  state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      err_q   <= 1'b0;
      dir_q   <= 1'b0;
`ifdef MOVE_HISTORY_REDO_EN
      redo_top_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      err_q   <= err_d;
      dir_q   <= dir_d;
`ifdef MOVE_HISTORY_REDO_EN
      redo_top_q <= redo_top_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (ram_we) begin
      mem_q[ram_addr] <= ram_wdata;
    end else if (ram_re) begin
      rdata_q <= mem_q[ram_addr][31:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_undo_q      <= 1'b0;
      out_color_q     <= 1'b0;
      out_initial_q   <= '0;
      out_moved_q     <= '0;
      out_moving_q    <= '0;
      out_captured_q  <= '0;
      out_castling_q  <= '0;
      out_enpassant_q <= '0;
    end else if (load_push) begin
      out_undo_q      <= 1'b0;
      out_color_q     <= in_color;
      out_initial_q   <= in_initial;
      out_moved_q     <= in_moved;
      out_moving_q    <= in_moving;
      out_captured_q  <= in_captured;
      out_castling_q  <= in_castling;
      out_enpassant_q <= in_enpassant;
    end else if (state_q == ST_POP_RD) begin
      out_undo_q      <= dir_q;
      out_initial_q   <= 64'd1 << rdata_q[5:0];
      out_moved_q     <= 64'd1 << rdata_q[11:6];
      out_moving_q    <= rdata_q[17:12];
      out_captured_q  <= rdata_q[23:18];
      out_castling_q  <= rdata_q[25:24];
      out_enpassant_q <= rdata_q[30:26];
      out_color_q     <= rdata_q[31];
    end
  end

  assign out_valid     = (state_q == ST_PUSH_OUT) || (state_q == ST_POP_OUT);
  assign out_undo      = out_undo_q;
  assign out_color     = out_color_q;
  assign out_initial   = out_initial_q;
  assign out_moved     = out_moved_q;
  assign out_moving    = out_moving_q;
  assign out_captured  = out_captured_q;
  assign out_castling  = out_castling_q;
  assign out_enpassant = out_enpassant_q;

endmodule
`default_nettype wire

// File: tb/tb_move_history_stack.sv
`default_nettype none
// Testbench for move_history_stack: random commit/undo traffic against a
// move-stack reference model, outputs matched through a scoreboard queue.
module tb_move_history_stack;
  localparam int DEPTH = 256;
  localparam int PTR_W = 8;

  typedef struct {
    logic        color;
    logic [63:0] ini;
    logic [63:0] mov;
    logic [5:0]  moving;
    logic [5:0]  capt;
    logic [1:0]  cast;
    logic [4:0]  ep;
  } move_t;

  typedef struct {
    logic  undo;
    move_t m;
    int    due;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        push_valid = 1'b0;
  logic        push_ready;
  logic        in_color = 1'b0;
  logic [63:0] in_initial = '0;
  logic [63:0] in_moved = '0;
  logic [5:0]  in_moving = '0;
  logic [5:0]  in_captured = '0;
  logic [1:0]  in_castling = '0;
  logic [4:0]  in_enpassant = '0;
  logic        undo_req = 1'b0;
  logic        undo_ack;
  logic        out_valid, out_undo, out_color;
  logic [63:0] out_initial, out_moved;
  logic [5:0]  out_moving, out_captured;
  logic [1:0]  out_castling;
  logic [4:0]  out_enpassant;
  logic [PTR_W:0] count;
  logic        empty, full, err;
`ifdef MOVE_HISTORY_REDO_EN
  logic        redo_req = 1'b0;
  logic        redo_ack;
`endif

  move_history_stack #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .push_valid(push_valid), .push_ready(push_ready),
    .in_color(in_color), .in_initial(in_initial), .in_moved(in_moved),
    .in_moving(in_moving), .in_captured(in_captured), .in_castling(in_castling),
    .in_enpassant(in_enpassant),
    .undo_req(undo_req), .undo_ack(undo_ack),
`ifdef MOVE_HISTORY_REDO_EN
    .redo_req(redo_req), .redo_ack(redo_ack),
`endif
    .out_valid(out_valid), .out_undo(out_undo), .out_color(out_color),
    .out_initial(out_initial), .out_moved(out_moved), .out_moving(out_moving),
    .out_captured(out_captured), .out_castling(out_castling),
    .out_enpassant(out_enpassant),
    .count(count), .empty(empty), .full(full), .err(err)
  );

  always #5 clk = ~clk;

  move_t mstack[$];
  exp_t  exp_q[$];
  int    busy = 0;
  bit    merr = 1'b0;
  int    cyc = 0;
  int    n_checks = 0;
  int    n_errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  function automatic move_t rand_move();
    move_t m;
    m.color  = 1'($urandom_range(0, 1));
    m.ini    = 64'd1 << $urandom_range(0, 63);
    m.mov    = 64'd1 << $urandom_range(0, 63);
    m.moving = 6'd1 << $urandom_range(0, 5);
    m.capt   = ($urandom_range(0, 2) == 0) ? 6'd0 : (6'd1 << $urandom_range(0, 5));
    m.cast   = 2'($urandom_range(0, 2));
    m.ep     = 5'($urandom_range(0, 31));
    return m;
  endfunction

  // Reference model: a plain stack of moves; ops occupy the block 1 (commit) or 2 (pop) cycles.
  always @(negedge clk) begin
    bit    idle, exp_rdy, p_acc, u_acc, legal;
    move_t m;
    exp_t  e;
    if (rst_n) begin
      idle    = (busy == 0);
      exp_rdy = idle && (mstack.size() < DEPTH);
      chk("push_ready", push_ready, exp_rdy);
      chk("count", count, mstack.size());
      chk("empty", empty, mstack.size() == 0);
      chk("full", full, mstack.size() == DEPTH);
      chk("err", err, merr);
      p_acc = push_valid && exp_rdy;
      u_acc = idle && !p_acc && undo_req;
      chk("undo_ack", undo_ack, u_acc);
      if (busy > 0) busy--;
      if (p_acc) begin
        legal = ($countones(in_initial) == 1) && ($countones(in_moved) == 1) &&
                ($countones(in_moving) == 1);
        if (legal) begin
          m = '{in_color, in_initial, in_moved, in_moving, in_captured, in_castling, in_enpassant};
          mstack.push_back(m);
          e.undo = 1'b0; e.m = m; e.due = cyc + 1;
          exp_q.push_back(e);
          busy = 1;
        end else begin
          merr = 1'b1;
        end
      end else if (u_acc) begin
        if (mstack.size() > 0) begin
          e.undo = 1'b1; e.m = mstack.pop_back(); e.due = cyc + 2;
          exp_q.push_back(e);
          busy = 2;
        end else begin
          merr = 1'b1;
        end
      end
    end
  end

  // Monitor: every out_valid strobe must match the oldest expectation on its due cycle.
  exp_t mon_e;
  always @(negedge clk) begin
    if (rst_n) begin
      if (exp_q.size() > 0 && exp_q[0].due < cyc) begin
        chk("missing out_valid", 64'd0, 64'd1);
        mon_e = exp_q.pop_front();
      end
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected out_valid", 64'd1, 64'd0);
        end else begin
          mon_e = exp_q.pop_front();
          chk("out_latency", cyc, mon_e.due);
          chk("out_undo", out_undo, mon_e.undo);
          chk("out_color", out_color, mon_e.m.color);
          chk("out_initial", out_initial, mon_e.m.ini);
          chk("out_moved", out_moved, mon_e.m.mov);
          chk("out_moving", out_moving, mon_e.m.moving);
          chk("out_captured", out_captured, mon_e.m.capt);
          chk("out_castling", out_castling, mon_e.m.cast);
          chk("out_enpassant", out_enpassant, mon_e.m.ep);
        end
      end
    end
  end

  task automatic drive_move(input move_t m);
    in_color     = m.color;
    in_initial   = m.ini;
    in_moved     = m.mov;
    in_moving    = m.moving;
    in_captured  = m.capt;
    in_castling  = m.cast;
    in_enpassant = m.ep;
  endtask

  task automatic wait_push();
    bit seen = 1'b0;
    for (int i = 0; i < 600 && !seen; i++) begin
      @(negedge clk);
      if (push_ready) seen = 1'b1;
    end
    if (!seen) chk("push handshake timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    push_valid = 1'b0;
  endtask

  task automatic wait_undo();
    bit seen = 1'b0;
    for (int i = 0; i < 600 && !seen; i++) begin
      @(negedge clk);
      if (undo_ack) seen = 1'b1;
    end
    if (!seen) chk("undo handshake timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    undo_req = 1'b0;
  endtask

  task automatic push_move(input move_t m);
    @(posedge clk); #1;
    drive_move(m);
    push_valid = 1'b1;
    wait_push();
  endtask

  task automatic do_undo();
    @(posedge clk); #1;
    undo_req = 1'b1;
    wait_undo();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    move_t m;
    bit    acked;
    // Reset values while rst_n is held low.
    repeat (2) @(negedge clk);
    chk("reset count", count, 0);
    chk("reset err", err, 0);
    chk("reset out_valid", out_valid, 0);
    chk("reset undo_ack", undo_ack, 0);
    chk("reset out_initial", out_initial, 0);
    chk("reset empty", empty, 1);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // e1 -> g1 castling by the white king.
    m = '{1'b1, 64'd1 << 3, 64'd1 << 1, 6'b100000, 6'd0, 2'b10, 5'd0};
    push_move(m);
    m = rand_move(); push_move(m);
    m = rand_move(); m.mov = 64'd1 << 36; push_move(m);
    do_undo();

    for (int i = 0; i < 150; i++) begin
      if (mstack.size() == 0 || ($urandom_range(0, 2) != 0 && mstack.size() < DEPTH))
        push_move(rand_move());
      else
        do_undo();
    end

    // Fill, then hold a push against the full stack until one undo frees a slot.
    while (mstack.size() < DEPTH) push_move(rand_move());
    @(posedge clk); #1;
    drive_move(rand_move());
    push_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("full while push pending", full, 1);
      chk("push_ready while full", push_ready, 0);
    end
    @(posedge clk); #1;
    undo_req = 1'b1;
    wait_undo();
    wait_push();
    repeat (2) @(negedge clk);
    chk("count refilled", count, DEPTH);

    // Commit and undo requested together at count 1: commit first.
    while (mstack.size() > 1) do_undo();
    @(posedge clk); #1;
    drive_move(rand_move());
    push_valid = 1'b1;
    undo_req   = 1'b1;
    wait_push();
    wait_undo();

    // Malformed origin square: consumed without storage, sticky error.
    m = rand_move(); m.ini = 64'h3;
    push_move(m);
    repeat (2) @(negedge clk);
    chk("err after bad push", err, 1);
    chk("count after bad push", count, 1);

    // Reset during the RAM read cycle of a pop.
    push_move(rand_move());
    @(posedge clk); #1;
    undo_req = 1'b1;
    acked = 1'b0;
    for (int i = 0; i < 20 && !acked; i++) begin
      @(negedge clk);
      if (undo_ack) acked = 1'b1;
    end
    if (!acked) chk("undo before reset timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    undo_req = 1'b0;
    rst_n    = 1'b0;
    exp_q.delete();
    mstack.delete();
    busy = 0;
    merr = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("mid-pop reset out_valid", out_valid, 0);
      chk("mid-pop reset count", count, 0);
      chk("mid-pop reset err", err, 0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Undo on an empty stack.
    do_undo();
    @(negedge clk);
    chk("err after empty undo", err, 1);
    chk("count after empty undo", count, 0);

    push_move(rand_move());
    do_undo();
    repeat (6) @(negedge clk);
    chk("scoreboard drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
